// File: rtl/run_detector_if.sv
// Bundle between the board-level pin mapping and the run detector core.
//   din       serial data sample
//   mode      run-type select (either/ones/zeros/non-overlapping)
//   en        sample enable
//   clr       synchronous event-counter clear
//   run_len   current run length
//   polarity  polarity of the current run
//   count     detection event count
//   detect    run of RUN_LEN accepted by the mode
//   saturated event count is all ones
// The master drives the controls and observes the results; the slave is the core.
interface run_detector_if #(
  parameter int CNT_W = 10
);
  logic             din;
  logic [1:0]       mode;
  logic             en;
  logic             clr;
  logic [3:0]       run_len;
  logic             polarity;
  logic [CNT_W-1:0] count;
  logic             detect;
  logic             saturated;

  modport master (
    output din, mode, en, clr,
    input  run_len, polarity, count, detect, saturated
  );

  modport slave (
    input  din, mode, en, clr,
    output run_len, polarity, count, detect, saturated
  );
endinterface

// File: rtl/run_detector.sv
// Consecutive-identical-bit run detector with a saturating event counter.
// run_detector (top, board pin names):
//   KEY[0]      clock, rising edge; KEY[3:1] unused
//   SW[0]       asynchronous active-low reset
//   SW[1]       serial data in
//   SW[3:2]     mode: 00 either/overlap, 01 ones, 10 zeros, 11 either/non-overlap
//   SW[4]       sample enable
//   SW[5]       synchronous counter clear
//   SW[17:6]    unused
//   LEDR[3:0]   current run length     LEDR[4]  current run polarity
//   LEDR[7:5]   0                      LEDR[17:8] event count, zero-extended
//   LEDG[0]     detect                 LEDG[1]  count saturated   LEDG[7:2] 0
// run_detector_core: clk, rst_n plus the slave side of run_detector_if.

module run_detector_core #(
  parameter int RUN_LEN = 4,
  parameter int CNT_W   = 10
) (
  input logic           clk,
  input logic           rst_n,
  run_detector_if.slave bus
);
  typedef enum logic [1:0] {
    MODE_EITHER = 2'b00,
    MODE_ONES   = 2'b01,
    MODE_ZEROS  = 2'b10,
    MODE_NONOVL = 2'b11
  } mode_t;

  localparam logic [3:0] RUN_L = 4'(RUN_LEN);

  mode_t            mode;
  logic [3:0]       run_q, run_nxt;
  logic             last_q, last_nxt;
  logic [CNT_W-1:0] cnt_q, cnt_nxt;
  logic             det_q, det_nxt;
  logic             accept;
  logic             evt;

  assign mode = mode_t'(bus.mode);

  always_comb begin
    run_nxt  = run_q;
    last_nxt = last_q;
    det_nxt  = det_q;
    cnt_nxt  = cnt_q;
    accept   = 1'b0;
    evt      = 1'b0;

    if (bus.en) begin
      if (run_q == '0 || bus.din != last_q) begin
        run_nxt  = 4'd1;
        last_nxt = bus.din;
      end else if (run_q < RUN_L) begin
        run_nxt = run_q + 4'd1;
      end else if (mode == MODE_NONOVL) begin
        run_nxt = 4'd1;
      end

      case (mode)
        MODE_ONES:  accept = last_nxt;
        MODE_ZEROS: accept = ~last_nxt;
        default:    accept = 1'b1;
      endcase

      // detect is registered from the next-state values so it is visible right
      // after the completing edge without a combinational path from SW to LEDG.
      det_nxt = (run_nxt == RUN_L) && accept;
      // run_q never exceeds RUN_L, so "!= RUN_L" means "reached from below".
      evt     = det_nxt && (run_q != RUN_L);
    end

    if (bus.clr) begin
      cnt_nxt = '0;
    end else if (evt && !(&cnt_q)) begin
      cnt_nxt = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q  <= '0;
      last_q <= 1'b0;
      cnt_q  <= '0;
      det_q  <= 1'b0;
    end else begin
      run_q  <= run_nxt;
      last_q <= last_nxt;
      cnt_q  <= cnt_nxt;
      det_q  <= det_nxt;
    end
  end

  assign bus.run_len   = run_q;
  assign bus.polarity  = last_q;
  assign bus.count     = cnt_q;
  assign bus.detect    = det_q;
  assign bus.saturated = &cnt_q;
endmodule

module run_detector #(
  parameter int RUN_LEN = 4,
  parameter int CNT_W   = 10
) (
  input  logic [3:0]  KEY,
  input  logic [17:0] SW,
  output logic [17:0] LEDR,
  output logic [7:0]  LEDG
);
  run_detector_if #(.CNT_W(CNT_W)) bus ();

  logic unused_pins;
  assign unused_pins = ^{KEY[3:1], SW[17:6]};

  assign bus.din  = SW[1];
  assign bus.mode = SW[3:2];
  assign bus.en   = SW[4];
  assign bus.clr  = SW[5];

  run_detector_core #(
    .RUN_LEN (RUN_LEN),
    .CNT_W   (CNT_W)
  ) u_core (
    .clk   (KEY[0]),
    .rst_n (SW[0]),
    .bus   (bus.slave)
  );

  assign LEDR = {10'(bus.count), 3'b000, bus.polarity, bus.run_len};
  assign LEDG = {6'b000000, bus.saturated, bus.detect};
endmodule

// File: tb/tb_run_detector.sv
// Directed bench for run_detector: RUN_LEN=4 with CNT_W=10 (dut_a) and
// CNT_W=2 (dut_b), both fed the same pins.
module tb_run_detector;
  logic        clk;
  logic        rst_n;
  logic [3:0]  key;
  logic [17:0] sw;
  logic [17:0] ledr_a, ledr_b;
  logic [7:0]  ledg_a, ledg_b;

  run_detector_if #(.CNT_W(10)) stim ();

  assign key = {3'b000, clk};
  assign sw  = {12'b0, stim.clr, stim.en, stim.mode, stim.din, rst_n};

  assign stim.run_len   = ledr_a[3:0];
  assign stim.polarity  = ledr_a[4];
  assign stim.count     = ledr_a[17:8];
  assign stim.detect    = ledg_a[0];
  assign stim.saturated = ledg_a[1];

  run_detector #(.RUN_LEN(4), .CNT_W(10)) dut_a (
    .KEY(key), .SW(sw), .LEDR(ledr_a), .LEDG(ledg_a)
  );
  run_detector #(.RUN_LEN(4), .CNT_W(2)) dut_b (
    .KEY(key), .SW(sw), .LEDR(ledr_b), .LEDG(ledg_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic       din;
    logic [1:0] mode;
    logic       en;
    logic       clr;
    logic [3:0] run;
    logic       pol;
    logic       det;
    logic [9:0] cnt;
    logic [1:0] cnt_b;
  } vec_t;

  vec_t vecs[$];
  int   total  = 0;
  int   passed = 0;

  task automatic add(input logic din, input logic [1:0] mode, input logic en,
                     input logic clr, input logic [3:0] run, input logic pol,
                     input logic det, input logic [9:0] cnt, input logic [1:0] cnt_b);
    vec_t v;
    v.din = din; v.mode = mode; v.en = en; v.clr = clr;
    v.run = run; v.pol = pol; v.det = det; v.cnt = cnt; v.cnt_b = cnt_b;
    vecs.push_back(v);
  endtask

  task automatic check(input string name,
                       input logic [17:0] r_got, input logic [7:0] g_got,
                       input logic [17:0] r_exp, input logic [7:0] g_exp);
    total++;
    if ({r_got, g_got} === {r_exp, g_exp}) passed++;
    else $display("FAIL %s: LEDR=%h LEDG=%h, expected LEDR=%h LEDG=%h",
                  name, r_got, g_got, r_exp, g_exp);
  endtask

  task automatic check_both(input string name, input logic [3:0] run, input logic pol,
                            input logic det, input logic [9:0] cnt, input logic [1:0] cnt_b);
    check({name, "_a"}, ledr_a, ledg_a, {cnt, 3'b000, pol, run}, {6'b0, 1'b0, det});
    check({name, "_b"}, ledr_b, ledg_b, {8'b0, cnt_b, 3'b000, pol, run},
          {6'b0, (cnt_b == 2'b11), det});
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    // din mode en clr | run pol det cnt cnt_b
    // mode 00: run of zeros, saturation hold is not a new event
    add(0, 2'b00, 1, 0, 1, 0, 0, 0, 0);
    add(0, 2'b00, 1, 0, 2, 0, 0, 0, 0);
    add(0, 2'b00, 1, 0, 3, 0, 0, 0, 0);
    add(0, 2'b00, 1, 0, 4, 0, 1, 1, 1);
    add(0, 2'b00, 1, 0, 4, 0, 1, 1, 1);
    // clear acts while disabled; everything else holds
    add(1, 2'b00, 0, 1, 4, 0, 1, 0, 0);
    // mode 11: nine ones, restart after each run
    add(1, 2'b11, 1, 0, 1, 1, 0, 0, 0);
    add(1, 2'b11, 1, 0, 2, 1, 0, 0, 0);
    add(1, 2'b11, 1, 0, 3, 1, 0, 0, 0);
    add(1, 2'b11, 1, 0, 4, 1, 1, 1, 1);
    add(1, 2'b11, 1, 0, 1, 1, 0, 1, 1);
    add(1, 2'b11, 1, 0, 2, 1, 0, 1, 1);
    add(1, 2'b11, 1, 0, 3, 1, 0, 1, 1);
    add(1, 2'b11, 1, 0, 4, 1, 1, 2, 2);
    add(1, 2'b11, 1, 0, 1, 1, 0, 2, 2);
    // mode 01: zero run ignored, one run detected
    add(0, 2'b01, 1, 0, 1, 0, 0, 2, 2);
    add(0, 2'b01, 1, 0, 2, 0, 0, 2, 2);
    add(0, 2'b01, 1, 0, 3, 0, 0, 2, 2);
    add(0, 2'b01, 1, 0, 4, 0, 0, 2, 2);
    add(1, 2'b01, 1, 0, 1, 1, 0, 2, 2);
    add(1, 2'b01, 1, 0, 2, 1, 0, 2, 2);
    add(1, 2'b01, 1, 0, 3, 1, 0, 2, 2);
    add(1, 2'b01, 1, 0, 4, 1, 1, 3, 3);
    // enable gating mid-run, dut_b stays saturated
    add(0, 2'b00, 1, 0, 1, 0, 0, 3, 3);
    add(1, 2'b00, 1, 0, 1, 1, 0, 3, 3);
    add(1, 2'b00, 1, 0, 2, 1, 0, 3, 3);
    add(1, 2'b00, 1, 0, 3, 1, 0, 3, 3);
    add(0, 2'b00, 0, 0, 3, 1, 0, 3, 3);
    add(0, 2'b00, 0, 0, 3, 1, 0, 3, 3);
    add(0, 2'b00, 0, 0, 3, 1, 0, 3, 3);
    add(1, 2'b00, 1, 0, 4, 1, 1, 4, 3);
    // mode 10: zero run detected
    add(0, 2'b10, 1, 0, 1, 0, 0, 4, 3);
    add(0, 2'b10, 1, 0, 2, 0, 0, 4, 3);
    add(0, 2'b10, 1, 0, 3, 0, 0, 4, 3);
    add(0, 2'b10, 1, 0, 4, 0, 1, 5, 3);
    // mode change mid-run: run kept, new mode rejects the zero run
    add(0, 2'b01, 1, 0, 4, 0, 0, 5, 3);
    // clear wins over a simultaneous event
    add(1, 2'b00, 1, 0, 1, 1, 0, 5, 3);
    add(1, 2'b00, 1, 0, 2, 1, 0, 5, 3);
    add(1, 2'b00, 1, 0, 3, 1, 0, 5, 3);
    add(1, 2'b00, 1, 1, 4, 1, 1, 0, 0);

    rst_n     = 1'b0;
    stim.din  = 1'b0;
    stim.mode = 2'b00;
    stim.en   = 1'b1;
    stim.clr  = 1'b0;
    #12;
    check_both("reset", 4'd0, 1'b0, 1'b0, 10'd0, 2'd0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      stim.din  = vecs[i].din;
      stim.mode = vecs[i].mode;
      stim.en   = vecs[i].en;
      stim.clr  = vecs[i].clr;
      step();
      check_both($sformatf("vec%0d", i), vecs[i].run, vecs[i].pol, vecs[i].det,
                 vecs[i].cnt, vecs[i].cnt_b);
    end

    // 23 ones in mode 11 from a saturated one-run: events at edges 4,8,..,20
    stim.din  = 1'b1;
    stim.mode = 2'b11;
    stim.en   = 1'b1;
    stim.clr  = 1'b0;
    for (int i = 0; i < 23; i++) step();
    check_both("pre_async", 4'd3, 1'b1, 1'b0, 10'd5, 2'd3);

    // asynchronous reset between edges
    #2 rst_n = 1'b0;
    #1;
    check_both("async_rst", 4'd0, 1'b0, 1'b0, 10'd0, 2'd0);
    step();
    check_both("rst_held", 4'd0, 1'b0, 1'b0, 10'd0, 2'd0);
    rst_n     = 1'b1;
    stim.mode = 2'b00;
    step();
    check_both("post_rst", 4'd1, 1'b1, 1'b0, 10'd0, 2'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/run_detector.md
RUN_DETECTOR -- requirements
Module: run_detector

Interface
REQ-001 SHALL have parameter RUN_LEN, default 4, the consecutive-identical-bit run length that constitutes a detection (legal 2..15).
REQ-002 SHALL have parameter CNT_W, default 10, the width of the detection event counter (legal 1..10).
REQ-003 SHALL have port KEY  input  4  where KEY[0] is the single clock (rising edge); KEY[3:1] are unused.
REQ-004 SHALL have port SW  input  18  where SW[0] is the reset, asynchronous and active-low; SW[1] is serial data in; SW[3:2] is the mode; SW[4] is the sample enable; SW[5] is the synchronous counter clear; SW[17:6] are unused.
REQ-005 SHALL have port LEDR  output  18  where LEDR[3:0] is the current run length, LEDR[4] is the current run polarity, LEDR[17:8] is the event count (zero-extended above CNT_W), and LEDR[7:5] are tied to 0.
REQ-006 SHALL have port LEDG  output  8  where LEDG[0] is detect, LEDG[1] is count saturated, and LEDG[7:2] are tied to 0.

Function
REQ-007 SHALL register all state (run_len 4b, last_bit, count CNT_W b) on posedge KEY[0] only; outputs are combinational from registers, with no input-to-output paths.
REQ-008 SHALL treat the mode SW[3:2] as follows: 00 = detect runs of either polarity, overlapping; 01 = runs of 1s only; 10 = runs of 0s only; 11 = either polarity, non-overlapping.
REQ-009 SHALL hold every register unchanged on any edge where SW[4]=0; clear SW[5] still acts when SW[4]=0.
REQ-010 SHALL, on an enabled edge with run_len==0 (first sample after reset), load run_len=1 and last_bit=SW[1].
REQ-011 SHALL, on an enabled edge with SW[1]!=last_bit, load run_len=1 and last_bit=SW[1].
REQ-012 SHALL, on an enabled edge with SW[1]==last_bit and run_len<RUN_LEN, increment run_len by 1.
REQ-013 SHALL, on an enabled edge with SW[1]==last_bit and run_len==RUN_LEN, hold run_len at RUN_LEN in modes 00/01/10 (saturate) and load run_len=1 in mode 11 (restart).
REQ-014 SHALL drive LEDG[0]=1 iff run_len==RUN_LEN and the mode accepts last_bit: 00/11 either value; 01 last_bit=1; 10 last_bit=0.
REQ-015 SHALL define a detection event as an enabled edge on which next run_len becomes RUN_LEN from a value below RUN_LEN and the mode accepts the run polarity; holding at saturation is not an event.
REQ-016 SHALL increment count by 1 per detection event, saturating at 2^CNT_W-1 with no wrap; LEDG[1]=1 iff count is all ones.
REQ-017 SHALL clear count to 0 on any edge with SW[5]=1; clear has priority over a simultaneous increment; run_len and last_bit are unaffected by clear.
REQ-018 SHALL evaluate a mode change mid-run on the next edge with the new mode; run_len and last_bit are not reset by a mode change.
REQ-019 SHALL have worst-case latency from the RUN_LEN-th matching sample edge to LEDG[0]=1 of zero cycles after that edge (visible immediately after the edge).

Reset
REQ-020 SHALL, while SW[0]=0, asynchronously force run_len=0, last_bit=0, and count=0, giving LEDR=0 and LEDG=0 regardless of clock.
REQ-021 SHALL, on reset assertion mid-run, discard the partial run; the first enabled edge after release follows REQ-010.
REQ-022 SHALL perform no clock-edge action while SW[0]=0; normal operation resumes on the first posedge after deassertion.

Verification (RUN_LEN=4, CNT_W=10)
REQ-023 SHALL cover mode 00: reset, then feed 0,0,0,0,0 -> run_len 1,2,3,4,4; LEDG[0] rises after the 4th edge and stays high; count=1.
REQ-024 SHALL cover mode 11: feed nine 1s -> run_len 1,2,3,4,1,2,3,4,1; two events, count=2; LEDG[0] high only after edges 4 and 8.
REQ-025 SHALL cover mode 01: feed 0000 then 1111 -> no event for the 0-run (LEDG[0]=0 with run_len=4); the 1-run gives LEDG[0]=1 and count=1.
REQ-026 SHALL cover enable and alternation: feed 1,1,1 then SW[4]=0 for 3 edges with SW[1]=0 -> run_len holds 3; re-enable and feed 1 -> run_len=4, event.
REQ-027 SHALL cover saturation and clear: with CNT_W=2 produce 5 events -> count=3, LEDG[1]=1; SW[5]=1 on the same edge as an event -> count=0.
REQ-028 SHALL cover async reset: assert SW[0]=0 between clock edges with run_len=3 and count=5 -> LEDR and LEDG go to 0 immediately, with no KEY[0] edge needed.
